// File: rtl/key_pio_irq.sv
// Avalon-MM push-button port: sync, optional debounce, press capture, IRQ mask.
// Define KEY_PIO_DEBOUNCE_EN to build the per-channel debounce counters.
`timescale 1ns/1ps
module key_pio_irq #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic                irq
);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_MASK = 2'd1,
        REG_RSVD = 2'd2,
        REG_EDGE = 2'd3
    } reg_addr_t;

    if (NUM_KEYS < 1 || NUM_KEYS > 32 || DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("key_pio_irq: NUM_KEYS must be 1..32 and DEBOUNCE_CYCLES >= 2");
    end

    reg_addr_t           addr_sel;
    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] stable_next;
    logic [NUM_KEYS-1:0] mask;
    logic [NUM_KEYS-1:0] edge_cap;
    logic [NUM_KEYS-1:0] edge_next;
    logic [31:0]         rd_value;
    logic                unused_wdata;

    assign addr_sel     = reg_addr_t'(address);
    assign unused_wdata = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '1;
        end else begin
            sync_meta <= key_in;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '1;
        end else begin
            sync <= sync_meta;
        end
    end

    // Counter clears on agreement, on any bounce back, and on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '{default: '0};
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (sync[i] == stable[i] || cnt[i] == CNT_MAX) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stable_next = stable;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (sync[i] != stable[i] && cnt[i] == CNT_MAX) begin
                stable_next[i] = sync[i];
            end
        end
    end
`else
    // Without debounce the stable register doubles as the second sync stage.
    always_comb begin
        stable_next = sync_meta;
    end
`endif

    // W1C first, then presses OR in so a same-cycle press survives the clear.
    always_comb begin
        edge_next = edge_cap;
        if (write && addr_sel == REG_EDGE) begin
            edge_next = edge_cap & ~writedata[NUM_KEYS-1:0];
        end
        edge_next = edge_next | (stable & ~stable_next);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable   <= '1;
            edge_cap <= '0;
            mask     <= '0;
            irq      <= 1'b0;
        end else begin
            stable   <= stable_next;
            edge_cap <= edge_next;
            if (write && addr_sel == REG_MASK) begin
                mask <= writedata[NUM_KEYS-1:0];
            end
            irq <= |(edge_cap & mask);
        end
    end

    always_comb begin
        rd_value = '0;
        case (addr_sel)
            REG_DATA: rd_value[NUM_KEYS-1:0] = stable;
            REG_MASK: rd_value[NUM_KEYS-1:0] = mask;
            REG_EDGE: rd_value[NUM_KEYS-1:0] = edge_cap;
            default:  rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_value;
        end
    end

endmodule

// File: tb/tb_key_pio_irq.sv
// Scoreboard bench for key_pio_irq: a 4-key instance (DEBOUNCE_CYCLES=4) and a 2-key instance.
`timescale 1ns/1ps
module tb_key_pio_irq;

    localparam int DB = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit DEB = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  addr_a, addr_b;
    logic        read_a, read_b, write_a, write_b;
    logic [31:0] wdata_a, wdata_b, rdata_a, rdata_b;
    logic [3:0]  key_a;
    logic [1:0]  key_b;
    logic        irq_a, irq_b;

    exp_t rdq_a[$];
    exp_t rdq_b[$];
    exp_t irqq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic rv_a = 1'b0, rv_b = 1'b0, irq_chk = 1'b0;

    key_pio_irq #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(DB)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(addr_a), .read(read_a), .write(write_a),
        .writedata(wdata_a), .readdata(rdata_a), .key_in(key_a), .irq(irq_a)
    );

    key_pio_irq #(.NUM_KEYS(2), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(addr_b), .read(read_b), .write(write_b),
        .writedata(wdata_b), .readdata(rdata_b), .key_in(key_b), .irq(irq_b)
    );

    always #5 clk = ~clk;

    // Read response is valid one cycle after the strobe.
    always @(posedge clk) begin
        rv_a <= read_a;
        rv_b <= read_b;
    end

    always @(negedge clk) begin
        if (rv_a) begin
            checks++;
            if (rdq_a.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read_a got %h expected no response", rdata_a);
            end else begin
                e = rdq_a.pop_front();
                if (rdata_a !== e.exp) begin
                    errors++;
                    $display("FAIL %s got %h expected %h", e.name, rdata_a, e.exp);
                end
            end
        end
        if (rv_b) begin
            checks++;
            if (rdq_b.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read_b got %h expected no response", rdata_b);
            end else begin
                e = rdq_b.pop_front();
                if (rdata_b !== e.exp) begin
                    errors++;
                    $display("FAIL %s got %h expected %h", e.name, rdata_b, e.exp);
                end
            end
        end
        if (irq_chk) begin
            checks++;
            if (irqq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_irq_check got %b expected no check", irq_a);
            end else begin
                e = irqq.pop_front();
                if ({31'b0, irq_a} !== e.exp) begin
                    errors++;
                    $display("FAIL %s got %b expected %0d", e.name, irq_a, e.exp);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rd_a(input logic [1:0] a, input logic [31:0] exp, input string nm);
        rdq_a.push_back(exp_t'{name: nm, exp: exp});
        addr_a = a;
        read_a = 1'b1;
        tick();
        read_a = 1'b0;
    endtask

    task automatic rd_b(input logic [1:0] a, input logic [31:0] exp, input string nm);
        rdq_b.push_back(exp_t'{name: nm, exp: exp});
        addr_b = a;
        read_b = 1'b1;
        tick();
        read_b = 1'b0;
    endtask

    task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
        addr_a  = a;
        wdata_a = d;
        write_a = 1'b1;
        tick();
        write_a = 1'b0;
    endtask

    task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
        addr_b  = a;
        wdata_b = d;
        write_b = 1'b1;
        tick();
        write_b = 1'b0;
    endtask

    // Samples irq as left by the most recent clock edge.
    task automatic chk_irq(input logic exp, input string nm);
        irqq.push_back(exp_t'{name: nm, exp: {31'b0, exp}});
        irq_chk = 1'b1;
        @(negedge clk);
        #1 irq_chk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        key_a   = 4'hF;
        key_b   = 2'h3;
        addr_a  = '0; addr_b  = '0;
        read_a  = 1'b0; read_b  = 1'b0;
        write_a = 1'b0; write_b = 1'b0;
        wdata_a = '0; wdata_b = '0;
        tick(3);
        reset_n = 1'b1;
        tick();

        // Reset state
        rd_a(2'd0, 32'h0000_000F, "reset_data");
        rd_a(2'd3, 32'h0, "reset_edge");
        rd_a(2'd1, 32'h0, "reset_mask");
        chk_irq(1'b0, "reset_irq");

        // Press key1: stable changes exactly LAT edges after the pin
        key_a[1] = 1'b0;
        tick(LAT - 1);
        rd_a(2'd0, 32'hF, "key1_one_before_latency");
        rd_a(2'd0, 32'hD, "key1_at_latency");
        rd_a(2'd3, 32'h2, "edge_key1");
        chk_irq(1'b0, "irq_unmasked");

        // Three-cycle glitch on key0
        key_a[0] = 1'b0;
        tick(2);
        rd_a(2'd0, DEB ? 32'hD : 32'hC, "glitch_mid_data");
        key_a[0] = 1'b1;
        tick(8);
        rd_a(2'd0, 32'hD, "glitch_after_data");
        rd_a(2'd3, DEB ? 32'h2 : 32'h3, "glitch_after_edge");
        wr_a(2'd3, 32'hF);
        rd_a(2'd3, 32'h0, "edge_w1c_all");

        // Release does not capture; mask + press raises irq one cycle after edge
        key_a[1] = 1'b1;
        tick(LAT + 2);
        rd_a(2'd0, 32'hF, "release_data");
        rd_a(2'd3, 32'h0, "release_no_edge");
        wr_a(2'd1, 32'h2);
        rd_a(2'd1, 32'h2, "mask_readback");
        chk_irq(1'b0, "irq_mask_no_edge");
        key_a[1] = 1'b0;
        tick(LAT);
        chk_irq(1'b0, "irq_same_edge_as_capture");
        tick();
        chk_irq(1'b1, "irq_asserted");
        rd_a(2'd3, 32'h2, "edge_before_clear");
        wr_a(2'd3, 32'h2);
        chk_irq(1'b1, "irq_hold_at_w1c_edge");
        tick();
        chk_irq(1'b0, "irq_cleared");
        rd_a(2'd3, 32'h0, "edge_cleared");

        // Press key2 on the same edge as W1C of bit2: set wins
        key_a[2] = 1'b0;
        tick(LAT - 1);
        wr_a(2'd3, 32'h4);
        rd_a(2'd3, 32'h4, "edge_set_wins");
        chk_irq(1'b0, "irq_masked_key2");
        wr_a(2'd3, 32'h4);
        rd_a(2'd3, 32'h0, "edge_w1c_key2");

        // DATA is read-only, reserved reads zero
        wr_a(2'd0, 32'h0);
        rd_a(2'd0, 32'h9, "data_read_only");
        wr_a(2'd2, 32'hFFFF_FFFF);
        rd_a(2'd2, 32'h0, "reserved_a");

        // Reset in the middle of a debounce
        key_a = 4'hF;
        tick(LAT + 2);
        key_a[3] = 1'b0;
        tick(2);
        reset_n  = 1'b0;
        key_a[3] = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(LAT + 2);
        rd_a(2'd0, 32'hF, "reset_mid_data");
        rd_a(2'd3, 32'h0, "reset_mid_edge");
        rd_a(2'd1, 32'h0, "reset_mid_mask");
        chk_irq(1'b0, "reset_mid_irq");

        // Two-key instance: upper bits read zero
        wr_b(2'd1, 32'hFFFF_FFFF);
        rd_b(2'd1, 32'h3, "b_mask_truncated");
        rd_b(2'd2, 32'h0, "b_reserved");
        rd_b(2'd0, 32'h3, "b_data");
        rd_b(2'd3, 32'h0, "b_edge");

        tick(3);
        checks++;
        if (rdq_a.size() + rdq_b.size() + irqq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending %0d expected 0",
                     rdq_a.size() + rdq_b.size() + irqq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
